// File: rtl/motor_pwm_drive.sv
// Differential-drive PWM generator: mixes speed/direction into left/right duties
// and emits 15-slot PWM periods with safe drain-to-idle and emergency stop.
module motor_pwm_drive #(
    parameter int PRESCALE   = 4,
    parameter int CENTER_DIR = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       estop,
    input  logic [3:0] speed,
    input  logic [3:0] dir,
    output logic       pwm_l,
    output logic       pwm_r,
    output logic [3:0] duty_l,
    output logic [3:0] duty_r,
    output logic       period_start,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [7:0]        PRESC_MAX = 8'(PRESCALE - 1);
    localparam logic signed [5:0] CENTER_S  = 6'(CENTER_DIR);

    state_t            state, state_nxt;
    logic [7:0]        presc_cnt, presc_nxt;
    logic [3:0]        slot_cnt, slot_nxt;
    logic [3:0]        duty_l_nxt, duty_r_nxt;
    logic              period_start_nxt;
    logic              tick, period_end;
    logic signed [5:0] delta_p0, mix_l_p0, mix_r_p0;
    logic [3:0]        tgt_l_p0, tgt_r_p0;

    function automatic logic [3:0] sat_u4(input logic signed [5:0] v);
        if (v < 6'sd0)
            return 4'd0;
        else if (v > 6'sd15)
            return 4'd15;
        else
            return v[3:0];
    endfunction

    // Stage p0: combinational mixing of the live command into duty targets
    always_comb begin
        delta_p0 = $signed({2'b00, dir}) - CENTER_S;
        mix_l_p0 = $signed({2'b00, speed}) + delta_p0;
        mix_r_p0 = $signed({2'b00, speed}) - delta_p0;
        tgt_l_p0 = sat_u4(mix_l_p0);
        tgt_r_p0 = sat_u4(mix_r_p0);
    end

    assign tick       = (state != IDLE) && (presc_cnt == PRESC_MAX);
    assign period_end = tick && (slot_cnt == 4'd14);

    always_comb begin
        state_nxt        = state;
        duty_l_nxt       = duty_l;
        duty_r_nxt       = duty_r;
        period_start_nxt = 1'b0;
        presc_nxt        = 8'd0;
        slot_nxt         = 4'd0;

        if (state != IDLE) begin
            if (tick) begin
                presc_nxt = 8'd0;
                slot_nxt  = period_end ? 4'd0 : slot_cnt + 4'd1;
            end else begin
                presc_nxt = presc_cnt + 8'd1;
                slot_nxt  = slot_cnt;
            end
        end

        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt        = RUN;
                    duty_l_nxt       = tgt_l_p0;
                    duty_r_nxt       = tgt_r_p0;
                    period_start_nxt = 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = DRAIN;
                end else if (period_end) begin
                    duty_l_nxt       = tgt_l_p0;
                    duty_r_nxt       = tgt_r_p0;
                    period_start_nxt = 1'b1;
                end
            end
            DRAIN: begin
                if (en) begin
                    state_nxt = RUN;
                    if (period_end) begin
                        duty_l_nxt       = tgt_l_p0;
                        duty_r_nxt       = tgt_r_p0;
                        period_start_nxt = 1'b1;
                    end
                end else if (period_end) begin
                    state_nxt  = IDLE;
                    duty_l_nxt = 4'd0;
                    duty_r_nxt = 4'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Emergency stop overrides every transition above
        if (estop) begin
            state_nxt        = IDLE;
            duty_l_nxt       = 4'd0;
            duty_r_nxt       = 4'd0;
            presc_nxt        = 8'd0;
            slot_nxt         = 4'd0;
            period_start_nxt = 1'b0;
        end
    end

    // Stage p1: registered state, counters and applied duties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            presc_cnt    <= 8'd0;
            slot_cnt     <= 4'd0;
            duty_l       <= 4'd0;
            duty_r       <= 4'd0;
            period_start <= 1'b0;
        end else begin
            state        <= state_nxt;
            presc_cnt    <= presc_nxt;
            slot_cnt     <= slot_nxt;
            duty_l       <= duty_l_nxt;
            duty_r       <= duty_r_nxt;
            period_start <= period_start_nxt;
        end
    end

    assign busy  = (state != IDLE);
    assign pwm_l = busy && (slot_cnt < duty_l);
    assign pwm_r = busy && (slot_cnt < duty_r);

endmodule

// File: tb/tb_motor_pwm_drive.sv
// Directed bench for motor_pwm_drive: duty scoreboard popped on period_start,
// plus PWM shape, drain, estop and reset checks on PRESCALE=1 and PRESCALE=4 instances.
module tb_motor_pwm_drive;

    typedef struct {
        int l;
        int r;
    } duty_t;

    logic       clk = 1'b0;
    logic       rst, en, estop;
    logic [3:0] speed, dir;

    logic       o1_pwm_l, o1_pwm_r, o1_ps, o1_busy;
    logic [3:0] o1_duty_l, o1_duty_r;
    logic       o4_pwm_l, o4_pwm_r, o4_ps, o4_busy;
    logic [3:0] o4_duty_l, o4_duty_r;

    duty_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    motor_pwm_drive #(.PRESCALE(1), .CENTER_DIR(8)) dut1 (
        .clk(clk), .rst(rst), .en(en), .estop(estop), .speed(speed), .dir(dir),
        .pwm_l(o1_pwm_l), .pwm_r(o1_pwm_r), .duty_l(o1_duty_l), .duty_r(o1_duty_r),
        .period_start(o1_ps), .busy(o1_busy)
    );

    motor_pwm_drive #(.PRESCALE(4), .CENTER_DIR(8)) dut4 (
        .clk(clk), .rst(rst), .en(en), .estop(estop), .speed(speed), .dir(dir),
        .pwm_l(o4_pwm_l), .pwm_r(o4_pwm_r), .duty_l(o4_duty_l), .duty_r(o4_duty_r),
        .period_start(o4_ps), .busy(o4_busy)
    );

    always #5 clk = ~clk;

    function automatic int clamp15(input int v);
        if (v < 0) return 0;
        if (v > 15) return 15;
        return v;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s, input int d);
        duty_t e;
        speed = 4'(s);
        dir   = 4'(d);
        e.l   = clamp15(s + (d - 8));
        e.r   = clamp15(s - (d - 8));
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input string tag, input int sel);
        duty_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_duty_l"}, (sel == 4) ? int'(o4_duty_l) : int'(o1_duty_l), e.l);
            chk({tag, "_duty_r"}, (sel == 4) ? int'(o4_duty_r) : int'(o1_duty_r), e.r);
        end
    endtask

    task automatic wait_ps(input string tag, input int sel, input int max_cyc, output int n);
        n = 0;
        while (((sel == 4) ? o4_ps : o1_ps) !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (((sel == 4) ? o4_ps : o1_ps) !== 1'b1)
            chk({tag, "_timeout"}, n, -1);
        else
            sb_pop(tag, sel);
    endtask

    // Counts PWM high cycles over one PRESCALE=1 period starting at slot 0
    task automatic run_period(input string tag, input int exp_hl, input int exp_hr);
        int hl = 0, hr = 0, pc = 0;
        for (int i = 0; i < 15; i++) begin
            hl += int'(o1_pwm_l);
            hr += int'(o1_pwm_r);
            pc += int'(o1_ps);
            @(negedge clk);
        end
        chk({tag, "_hi_l"}, hl, exp_hl);
        chk({tag, "_hi_r"}, hr, exp_hr);
        chk({tag, "_ps_per_period"}, pc, 1);
        chk({tag, "_ps_at_15"}, int'(o1_ps), 1);
        sb_pop(tag, 1);
    endtask

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; estop = 1'b0; speed = 4'd0; dir = 4'd8;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(o1_busy), 0);
        chk("rst_pwm", int'({o1_pwm_l, o1_pwm_r}), 0);
        chk("rst_duty", int'({o1_duty_l, o1_duty_r}), 0);
        chk("rst_ps", int'(o1_ps), 0);

        // straight ahead, PRESCALE=1
        rst = 1'b0;
        drive(5, 8);
        en = 1'b1;
        wait_ps("start", 1, 5, n);
        chk("start_latency", n, 1);
        drive(5, 8);
        run_period("p5", 5, 5);

        // mixing and saturation
        @(negedge clk);
        drive(10, 12);
        wait_ps("mix_10_12", 1, 20, n);
        @(negedge clk);
        drive(14, 15);
        wait_ps("mix_14_15", 1, 20, n);
        drive(14, 15);
        run_period("p15_7", 15, 7);
        @(negedge clk);
        drive(2, 0);
        wait_ps("mix_2_0", 1, 20, n);
        drive(2, 0);
        run_period("p0_10", 0, 10);

        // mid-period command change is deferred
        @(negedge clk);
        drive(5, 8);
        wait_ps("defer_a", 1, 20, n);
        repeat (3) @(negedge clk);
        drive(12, 8);
        repeat (5) @(negedge clk);
        chk("defer_hold", int'(o1_duty_l), 5);
        wait_ps("defer_b", 1, 20, n);

        // emergency stop at slot 2 with full duty
        @(negedge clk);
        drive(15, 8);
        wait_ps("es_pre", 1, 20, n);
        repeat (2) @(negedge clk);
        chk("es_pwm_before", int'(o1_pwm_l), 1);
        estop = 1'b1;
        @(negedge clk);
        chk("es_pwm", int'({o1_pwm_l, o1_pwm_r}), 0);
        chk("es_busy", int'(o1_busy), 0);
        chk("es_duty", int'({o1_duty_l, o1_duty_r}), 0);
        chk("es_ps", int'(o1_ps), 0);
        @(negedge clk);
        chk("es_hold_idle", int'(o1_busy), 0);
        drive(15, 8);
        estop = 1'b0;
        wait_ps("es_release", 1, 3, n);
        chk("es_release_lat", n, 1);

        // asynchronous reset mid-period
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_busy", int'(o1_busy), 0);
        chk("arst_pwm", int'({o1_pwm_l, o1_pwm_r}), 0);
        chk("arst_duty", int'({o1_duty_l, o1_duty_r}), 0);
        chk("arst_ps", int'(o1_ps), 0);
        @(negedge clk);
        drive(3, 9);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_run_busy", int'(o1_busy), 1);
        wait_ps("arst_restart", 1, 0, n);

        // drain on the PRESCALE=4 instance
        en = 1'b0; estop = 1'b1;
        @(negedge clk);
        estop = 1'b0;
        @(negedge clk);
        drive(7, 8);
        en = 1'b1;
        wait_ps("dr_start", 4, 5, n);
        repeat (25) @(negedge clk);
        chk("dr_pwm_r_slot6", int'(o4_pwm_r), 1);
        en = 1'b0;
        repeat (5) @(negedge clk);
        chk("dr_busy_30", int'(o4_busy), 1);
        chk("dr_duty_held", int'(o4_duty_l), 7);
        chk("dr_pwm_l_slot7", int'(o4_pwm_l), 0);
        repeat (29) @(negedge clk);
        chk("dr_busy_59", int'(o4_busy), 1);
        @(negedge clk);
        chk("dr_idle_60", int'(o4_busy), 0);
        chk("dr_duty_cleared", int'({o4_duty_l, o4_duty_r}), 0);

        // re-enable mid-drain keeps the period and reloads at its end
        drive(7, 8);
        en = 1'b1;
        wait_ps("rd_start", 4, 5, n);
        repeat (20) @(negedge clk);
        en = 1'b0;
        drive(3, 8);
        repeat (10) @(negedge clk);
        chk("rd_busy", int'(o4_busy), 1);
        en = 1'b1;
        wait_ps("rd_reload", 4, 40, n);
        chk("rd_reload_time", n, 30);

        chk("sb_leftover", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
